// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, stall vectors,
// CP0 Status/Cause field positions and the exception priority encoder.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_IP_HI  = 15;

    // Bit positions within the MEM-stage exception flag vector.
    localparam int unsigned FLAG_SYSCALL = 0;
    localparam int unsigned FLAG_INVALID = 1;
    localparam int unsigned FLAG_TRAP    = 2;
    localparam int unsigned FLAG_OV      = 3;
    localparam int unsigned FLAG_ERET    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StHold
    } exc_state_e;

    function automatic logic [31:0] exc_prio(input logic int_pending, input logic [4:0] flags);
        if (int_pending)                 return EXC_INT;
        else if (flags[FLAG_INVALID])    return EXC_INVALID;
        else if (flags[FLAG_SYSCALL])    return EXC_SYSCALL;
        else if (flags[FLAG_TRAP])       return EXC_TRAP;
        else if (flags[FLAG_OV])         return EXC_OV;
        else if (flags[FLAG_ERET])       return EXC_ERET;
        else                             return EXC_NONE;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low clear.
module int_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks the highest-priority MEM-stage event, pulses the CP0
// exception inputs for one cycle while flushing and redirecting, and arbitrates pipeline stalls.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_int,
    input  logic        i_timer_int,
    input  logic [31:0] i_cp0_status,
    input  logic [31:0] i_cp0_cause,
    input  logic [31:0] i_cp0_epc,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_pc,
    input  logic        i_mem_in_delayslot,
    input  logic [4:0]  i_mem_exc,
    input  logic        i_stall_req_id,
    input  logic        i_stall_req_ex,
    output logic [5:0]  o_int_sync,
    output logic [31:0] o_excepttype,
    output logic [31:0] o_current_inst_addr,
    output logic        o_is_in_delayslot,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic [5:0]  o_stall,
    output logic        o_busy
);

    exc_state_e  state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] code_q, addr_q, target_q;
    logic        ds_q;

    logic [5:0]  int_q;
    logic        int_pending;
    logic [31:0] dec_code;
    logic        take;
    logic [5:0]  stall_arb;

    int_sync #(
        .WIDTH(6)
    ) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i_int),
        .q    (int_q)
    );

    assign o_int_sync = {int_q[5] | i_timer_int, int_q[4:0]};

    assign int_pending = i_cp0_status[STATUS_IE] & ~i_cp0_status[STATUS_EXL] &
                         (|(i_cp0_status[STATUS_IM_HI:STATUS_IM_LO] &
                            i_cp0_cause[CAUSE_IP_HI:CAUSE_IP_LO]));
    assign dec_code    = exc_prio(int_pending, i_mem_exc);
    assign take        = (state_q == StIdle) && i_mem_valid && (dec_code != EXC_NONE);

    assign stall_arb = i_stall_req_ex ? STALL_EX :
                       i_stall_req_id ? STALL_ID : STALL_NONE;

    logic unused_cp0;
    assign unused_cp0 = ^{i_cp0_status[31:16], i_cp0_status[7:2],
                          i_cp0_cause[31:16], i_cp0_cause[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            addr_q   <= '0;
            ds_q     <= 1'b0;
            target_q <= '0;
        end else if (take) begin
            code_q   <= dec_code;
            addr_q   <= i_mem_pc;
            ds_q     <= i_mem_in_delayslot;
            target_q <= (dec_code == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;
        end
    end

    always_comb begin
        state_d             = state_q;
        hold_d              = hold_q;
        o_excepttype        = '0;
        o_current_inst_addr = '0;
        o_is_in_delayslot   = 1'b0;
        o_flush             = 1'b0;
        o_new_pc            = '0;
        o_stall             = stall_arb;
        o_busy              = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (take) state_d = StFlush;
            end
            StFlush: begin
                o_excepttype        = code_q;
                o_current_inst_addr = addr_q;
                o_is_in_delayslot   = ds_q;
                o_flush             = 1'b1;
                o_new_pc            = target_q;
                o_stall             = STALL_NONE;
                if (HOLD_CYCLES > 0) begin
                    state_d = StHold;
                    hold_d  = 4'(HOLD_CYCLES - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (hold_q == 4'd0) state_d = StIdle;
                else                hold_d  = hold_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios followed by random traffic, all
// compared every cycle against a cycle-count based reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC  = 32'h0000_0020;
    localparam int          HOLD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  i_int = '0;
    logic        i_timer_int = 1'b0;
    logic [31:0] i_cp0_status = '0;
    logic [31:0] i_cp0_cause;
    logic [31:0] i_cp0_epc = '0;
    logic        i_mem_valid = 1'b0;
    logic [31:0] i_mem_pc = '0;
    logic        i_mem_in_delayslot = 1'b0;
    logic [4:0]  i_mem_exc = '0;
    logic        i_stall_req_id = 1'b0;
    logic        i_stall_req_ex = 1'b0;
    logic [5:0]  o_int_sync;
    logic [31:0] o_excepttype;
    logic [31:0] o_current_inst_addr;
    logic        o_is_in_delayslot;
    logic        o_flush;
    logic [31:0] o_new_pc;
    logic [5:0]  o_stall;
    logic        o_busy;

    always #5 clk = ~clk;

    // CP0 Cause IP[7:2] mirrors the synchronised hardware interrupt lines.
    assign i_cp0_cause = {16'h0, o_int_sync, 2'b00, 8'h00};

    exc_ctrl #(
        .EXC_VECTOR (VEC),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_int              (i_int),
        .i_timer_int        (i_timer_int),
        .i_cp0_status       (i_cp0_status),
        .i_cp0_cause        (i_cp0_cause),
        .i_cp0_epc          (i_cp0_epc),
        .i_mem_valid        (i_mem_valid),
        .i_mem_pc           (i_mem_pc),
        .i_mem_in_delayslot (i_mem_in_delayslot),
        .i_mem_exc          (i_mem_exc),
        .i_stall_req_id     (i_stall_req_id),
        .i_stall_req_ex     (i_stall_req_ex),
        .o_int_sync         (o_int_sync),
        .o_excepttype       (o_excepttype),
        .o_current_inst_addr(o_current_inst_addr),
        .o_is_in_delayslot  (o_is_in_delayslot),
        .o_flush            (o_flush),
        .o_new_pc           (o_new_pc),
        .o_stall            (o_stall),
        .o_busy             (o_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: interrupt history and cycles elapsed since the last accepted event.
    logic [5:0]  m_s1 = '0, m_s2 = '0;
    int          since_dec = 1000;
    logic [31:0] m_code = '0, m_addr = '0, m_tgt = '0;
    logic        m_ds = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_code(input logic ip, input logic [4:0] f);
        logic [31:0] codes [6];
        logic [5:0]  hit;
        codes = '{32'h1, 32'ha, 32'h8, 32'hd, 32'hc, 32'he};
        hit   = {f[4], f[3], f[2], f[0], f[1], ip};  // hit[0] is the most urgent
        for (int k = 0; k < 6; k++) if (hit[k]) return codes[k];
        return 32'h0;
    endfunction

    function automatic logic [5:0] exp_sync();
        return {m_s2[5] | i_timer_int, m_s2[4:0]};
    endfunction

    task automatic check_all();
        logic       fl;
        logic       busy;
        logic [5:0] st;
        fl   = (since_dec == 1);
        busy = (since_dec <= 1 + HOLD);
        st   = fl ? 6'h00 : i_stall_req_ex ? 6'h0f : i_stall_req_id ? 6'h07 : 6'h00;
        chk("int_sync",   32'(o_int_sync),          32'(exp_sync()));
        chk("excepttype", o_excepttype,             fl ? m_code : 32'h0);
        chk("inst_addr",  o_current_inst_addr,      fl ? m_addr : 32'h0);
        chk("delayslot",  32'(o_is_in_delayslot),   32'(fl & m_ds));
        chk("flush",      32'(o_flush),             32'(fl));
        chk("new_pc",     o_new_pc,                 fl ? m_tgt : 32'h0);
        chk("stall",      32'(o_stall),             32'(st));
        chk("busy",       32'(o_busy),              32'(busy));
    endtask

    // One clock: check mid-cycle, evaluate the model's decision, cross the edge.
    task automatic cycle();
        logic        ip, dec;
        logic [31:0] c;
        #3;
        check_all();
        ip  = i_cp0_status[0] & ~i_cp0_status[1] & (|(i_cp0_status[15:8] & {exp_sync(), 2'b00}));
        c   = ref_code(ip, i_mem_exc);
        dec = (since_dec > 1 + HOLD) && i_mem_valid && (c != 32'h0);
        @(posedge clk);
        m_s2 = m_s1;
        m_s1 = i_int;
        if (dec) begin
            since_dec = 1;
            m_code    = c;
            m_addr    = i_mem_pc;
            m_ds      = i_mem_in_delayslot;
            m_tgt     = (c == 32'he) ? i_cp0_epc : VEC;
        end else if (since_dec < 1000) begin
            since_dec++;
        end
        #1;
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        since_dec = 1000;
    endtask

    task automatic clear_inputs();
        i_int = '0; i_timer_int = 1'b0; i_cp0_status = '0; i_cp0_epc = '0;
        i_mem_valid = 1'b0; i_mem_pc = '0; i_mem_in_delayslot = 1'b0; i_mem_exc = '0;
        i_stall_req_id = 1'b0; i_stall_req_ex = 1'b0;
    endtask

    initial begin
        // Reset: outputs all zero while held
        clear_inputs();
        model_reset();
        @(posedge clk);
        #2;
        chk("rst_flush", 32'(o_flush), 32'h0);
        chk("rst_exc",   o_excepttype, 32'h0);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_busy",  32'(o_busy),  32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // Stall arbitration
        i_stall_req_ex = 1'b1; #3; chk("stall_ex", 32'(o_stall), 32'h0f); #(-0); cycle();
        i_stall_req_ex = 1'b0; i_stall_req_id = 1'b1; cycle();
        i_stall_req_ex = 1'b1; cycle();
        i_stall_req_ex = 1'b0; i_stall_req_id = 1'b0;

        // Syscall at 0x100, then hold, then idle
        i_mem_valid = 1'b1; i_mem_exc = 5'b00001; i_mem_pc = 32'h100;
        cycle();
        i_mem_valid = 1'b0; i_mem_exc = '0;
        #3;
        chk("sys_code", o_excepttype, 32'h8);
        chk("sys_pc",   o_new_pc,     32'h20);
        cycle();
        i_stall_req_ex = 1'b1;
        cycle();
        i_stall_req_ex = 1'b0;
        cycle();

        // Eret redirects to EPC
        i_cp0_epc = 32'h1234; i_mem_valid = 1'b1; i_mem_exc = 5'b10000; i_mem_pc = 32'h2000;
        i_mem_in_delayslot = 1'b1;
        cycle();
        i_mem_valid = 1'b0; i_mem_exc = '0; i_mem_in_delayslot = 1'b0;
        #3;
        chk("eret_code", o_excepttype, 32'he);
        chk("eret_pc",   o_new_pc,     32'h1234);
        repeat (3) cycle();

        // Interrupt sync latency, then interrupt beats trap
        i_cp0_status = 32'h0000_ff01;
        i_int[2] = 1'b1;
        cycle();
        #3; chk("sync_1edge", 32'(o_int_sync[2]), 32'h0);
        cycle();
        #3; chk("sync_2edge", 32'(o_int_sync[2]), 32'h1);
        i_mem_valid = 1'b1; i_mem_exc = 5'b00100; i_mem_pc = 32'h300;
        cycle();
        i_mem_valid = 1'b0; i_mem_exc = '0;
        #3; chk("int_wins", o_excepttype, 32'h1);
        repeat (3) cycle();

        // Masked by EXL, then no valid instruction, then taken
        i_cp0_status = 32'h0000_ff03; i_mem_valid = 1'b1; i_mem_pc = 32'h400;
        repeat (2) cycle();
        i_cp0_status = 32'h0000_ff01; i_mem_valid = 1'b0;
        repeat (2) cycle();
        i_mem_valid = 1'b1;
        cycle();
        i_mem_valid = 1'b0;
        #3; chk("int_after_exl", o_excepttype, 32'h1);
        cycle();
        i_int = '0; i_cp0_status = '0;
        repeat (4) cycle();

        // Reset asserted during the flush cycle
        i_mem_valid = 1'b1; i_mem_exc = 5'b01000; i_mem_pc = 32'h500;
        cycle();
        i_mem_valid = 1'b0; i_mem_exc = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_flush", 32'(o_flush),  32'h0);
        chk("midrst_exc",   o_excepttype,  32'h0);
        chk("midrst_stall", 32'(o_stall),  32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] sts [4];
            sts = '{32'h0000_ff01, 32'h0000_ff03, 32'h0000_ff00, 32'h0000_0401};
            if ($urandom_range(0, 7) == 0) i_int = 6'($urandom);
            i_timer_int        = ($urandom_range(0, 15) == 0);
            i_cp0_status       = sts[$urandom_range(0, 3)];
            i_cp0_epc          = $urandom & 32'hffff_fffc;
            i_mem_valid        = ($urandom_range(0, 3) != 0);
            i_mem_pc           = $urandom & 32'hffff_fffc;
            i_mem_in_delayslot = 1'($urandom);
            i_mem_exc          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            i_stall_req_id     = 1'($urandom);
            i_stall_req_ex     = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
